// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA mode-timing types, standard modes and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int C_COORD_W = 12;

    typedef logic [C_COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t active;
        coord_t front;
        coord_t sync;
        coord_t back;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } mode_timing_t;

    // Request flags carried down the pixel-data delay line
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } pipe_bits_t;

    localparam mode_timing_t C_MODE_1024X600_50M = '{
        h: '{active: 12'd1024, front: 12'd80, sync: 12'd120, back: 12'd122},
        v: '{active: 12'd600,  front: 12'd34, sync: 12'd6,   back: 12'd26}
    };

    localparam mode_timing_t C_MODE_640X480_25M = '{
        h: '{active: 12'd640, front: 12'd16, sync: 12'd96, back: 12'd48},
        v: '{active: 12'd480, front: 12'd10, sync: 12'd2,  back: 12'd33}
    };

    function automatic coord_t axis_total(input axis_timing_t t);
        return t.active + t.front + t.sync + t.back;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Pixel request / DAC bundle between source, generator and pins.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int R_W = 3,
    parameter int G_W = 3,
    parameter int B_W = 2
);
    logic                     pix_en;
    logic [11:0]              x;
    logic [11:0]              y;
    logic                     req_active;
    logic                     line_start;
    logic                     frame_start;
    logic [R_W+G_W+B_W-1:0]   rgb_in;
    logic [R_W-1:0]           red;
    logic [G_W-1:0]           green;
    logic [B_W-1:0]           blue;
    logic                     hsync;
    logic                     vsync;
    logic                     de;

    modport master (
        input  pix_en, rgb_in,
        output x, y, req_active, line_start, frame_start,
               red, green, blue, hsync, vsync, de
    );

    modport slave (
        output pix_en, rgb_in,
        input  x, y, req_active, line_start, frame_start,
               red, green, blue, hsync, vsync, de
    );
endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : Wrapping raster counter for one axis with active/sync flags.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 1024,
    parameter int FRONT  = 80,
    parameter int SYNC   = 120,
    parameter int BACK   = 122
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_en,
    output coord_t o_count,
    output logic   o_active,
    output logic   o_sync,
    output logic   o_wrap
);
    localparam axis_timing_t C_TIMING = '{
        active: 12'(ACTIVE), front: 12'(FRONT), sync: 12'(SYNC), back: 12'(BACK)
    };
    localparam coord_t C_LAST       = axis_total(C_TIMING) - 12'd1;
    localparam coord_t C_ACTIVE     = 12'(ACTIVE);
    localparam coord_t C_SYNC_START = 12'(ACTIVE + FRONT);
    localparam coord_t C_SYNC_END   = 12'(ACTIVE + FRONT + SYNC);

    coord_t r_count;

    assign o_wrap   = i_en && (r_count == C_LAST);
    assign o_count  = r_count;
    assign o_active = (r_count < C_ACTIVE);
    assign o_sync   = (r_count >= C_SYNC_START) && (r_count < C_SYNC_END);

    // Reset parks on the last position so the first enabled slot is 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= C_LAST;
        end else if (i_en) begin
            r_count <= o_wrap ? '0 : r_count + 12'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster generator with aligned RGB/sync/de.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = 1024,
    parameter int H_FRONT   = 80,
    parameter int H_SYNC    = 120,
    parameter int H_BACK    = 122,
    parameter int V_ACTIVE  = 600,
    parameter int V_FRONT   = 34,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 26,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIPE      = 2,
    parameter int R_W       = 3,
    parameter int G_W       = 3,
    parameter int B_W       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_timing_gen_if.master       vga_bus
);
    localparam int C_RGB_W = R_W + G_W + B_W;

    coord_t     w_h;
    coord_t     w_v;
    logic       w_h_active;
    logic       w_h_sync;
    logic       w_h_wrap;
    logic       w_v_active;
    logic       w_v_sync;
    logic       w_v_wrap_unused;
    pipe_bits_t w_req;
    pipe_bits_t w_last;

    pipe_bits_t         r_pipe [PIPE];
    logic               r_de;
    logic               r_hsync;
    logic               r_vsync;
    logic [C_RGB_W-1:0] r_rgb;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_counter (
        .clk      (clk),
        .rst      (rst),
        .i_en     (vga_bus.pix_en),
        .o_count  (w_h),
        .o_active (w_h_active),
        .o_sync   (w_h_sync),
        .o_wrap   (w_h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_counter (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_h_wrap),
        .o_count  (w_v),
        .o_active (w_v_active),
        .o_sync   (w_v_sync),
        .o_wrap   (w_v_wrap_unused)
    );

    assign w_req.active = w_h_active && w_v_active;
    assign w_req.hsync  = w_h_sync;
    assign w_req.vsync  = w_v_sync;
    assign w_last       = r_pipe[PIPE-1];

    // Delay line matches the upstream source's PIPE-slot pixel latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (vga_bus.pix_en) begin
            r_pipe[0] <= w_req;
            for (int i = 1; i < PIPE; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_de    <= 1'b0;
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
            r_rgb   <= '0;
        end else if (vga_bus.pix_en) begin
            r_de    <= w_last.active;
            r_hsync <= w_last.hsync ? HSYNC_POL : ~HSYNC_POL;
            r_vsync <= w_last.vsync ? VSYNC_POL : ~VSYNC_POL;
            r_rgb   <= w_last.active ? vga_bus.rgb_in : '0;
        end
    end

    assign vga_bus.x           = w_h;
    assign vga_bus.y           = w_v;
    assign vga_bus.req_active  = w_req.active;
    assign vga_bus.line_start  = (w_h == '0) && w_v_active;
    assign vga_bus.frame_start = (w_h == '0) && (w_v == '0);
    assign vga_bus.red         = r_rgb[R_W-1:0];
    assign vga_bus.green       = r_rgb[R_W+G_W-1:R_W];
    assign vga_bus.blue        = r_rgb[C_RGB_W-1:R_W+G_W];
    assign vga_bus.hsync       = r_hsync;
    assign vga_bus.vsync       = r_vsync;
    assign vga_bus.de          = r_de;
endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench: default, 640x480 and tiny modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.R_W(3), .G_W(3), .B_W(2)) if0 ();
    vga_timing_gen_if #(.R_W(3), .G_W(3), .B_W(2)) if1 ();
    vga_timing_gen_if #(.R_W(3), .G_W(3), .B_W(2)) if2 ();

    vga_timing_gen u_d0 (.clk(clk), .rst(rst), .vga_bus(if0));

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_ACTIVE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE(1)
    ) u_d1 (.clk(clk), .rst(rst), .vga_bus(if1));

    // Tiny mode with zero-length H front porch and V back porch
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(0), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(0),
        .PIPE(4)
    ) u_d2 (.clk(clk), .rst(rst), .vga_bus(if2));

    // Counter position and region flags of request slot j (slot 0 = reset state)
    function automatic void slot_model(input int ha, input int hf, input int hs, input int hb,
                                       input int va, input int vf, input int vs, input int vb,
                                       input int j, output int h, output int v,
                                       output bit act, output bit hreg, output bit vreg);
        int ht, vt, p;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (j < 0) begin
            h = ht - 1; v = vt - 1; act = 1'b0; hreg = 1'b0; vreg = 1'b0;
            return;
        end
        p    = (ht * vt - 1 + j) % (ht * vt);
        h    = p % ht;
        v    = p / ht;
        act  = (h < ha) && (v < va);
        hreg = (h >= ha + hf) && (h < ha + hf + hs);
        vreg = (v >= va + vf) && (v < va + vf + vs);
    endfunction

    function automatic logic [7:0] tiny_pat(input int h, input int v);
        return 8'((h * 29 + v * 71 + 5) & 255);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        if0.pix_en = 1'b0; if1.pix_en = 1'b0; if2.pix_en = 1'b0;
        if0.rgb_in = 8'hFF; if1.rgb_in = 8'hFF; if2.rgb_in = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if0.x, if0.y} !== {12'd1345, 12'd665}) begin
            failures++;
            $display("FAIL reset_d0_xy got=%0d,%0d exp=1345,665", if0.x, if0.y);
        end
        checks++;
        if ({if0.req_active, if0.line_start, if0.frame_start} !== 3'b000) begin
            failures++;
            $display("FAIL reset_d0_strobes got=%b exp=000", {if0.req_active, if0.line_start, if0.frame_start});
        end
        checks++;
        if ({if0.de, if0.hsync, if0.vsync, if0.blue, if0.green, if0.red} !== {3'b011, 8'd0}) begin
            failures++;
            $display("FAIL reset_d0_outputs got=%b exp=01100000000",
                     {if0.de, if0.hsync, if0.vsync, if0.blue, if0.green, if0.red});
        end
        checks++;
        if ({if1.x, if1.y, if1.hsync, if1.vsync} !== {12'd799, 12'd524, 2'b00}) begin
            failures++;
            $display("FAIL reset_d1 got x=%0d y=%0d hs=%b vs=%b exp x=799 y=524 hs=0 vs=0",
                     if1.x, if1.y, if1.hsync, if1.vsync);
        end
        checks++;
        if ({if2.x, if2.y, if2.hsync, if2.vsync} !== {12'd12, 12'd7, 2'b11}) begin
            failures++;
            $display("FAIL reset_d2 got x=%0d y=%0d hs=%b vs=%b exp x=12 y=7 hs=1 vs=1",
                     if2.x, if2.y, if2.hsync, if2.vsync);
        end
    endtask

    task automatic test_frame_start();
        rst = 1'b0;
        if0.pix_en = 1'b1;
        if0.rgb_in = 8'h00;
        @(posedge clk);
        #1;
        checks++;
        if ({if0.x, if0.y, if0.frame_start, if0.line_start, if0.req_active, if0.de} !==
            {12'd0, 12'd0, 4'b1110}) begin
            failures++;
            $display("FAIL frame_start got x=%0d y=%0d fs=%b ls=%b ra=%b de=%b exp 0 0 1 1 1 0",
                     if0.x, if0.y, if0.frame_start, if0.line_start, if0.req_active, if0.de);
        end
    endtask

    // Continues from slot 1; PIPE=2 so outputs at edge m carry request m-3
    task automatic test_default_lines();
        int h, v, hq, vq, hs_low, de_hi;
        bit a, hr, vr, a2, hr2, vr2;
        logic [37:0] got, want;
        hs_low = 0; de_hi = 0;
        for (int m = 2; m <= 4041; m++) begin
            slot_model(1024, 80, 120, 122, 600, 34, 6, 26, m - 3, hq, vq, a, hr, vr);
            if0.rgb_in = 8'(hq);
            if0.pix_en = 1'b1;
            @(posedge clk);
            #1;
            slot_model(1024, 80, 120, 122, 600, 34, 6, 26, m, h, v, a2, hr2, vr2);
            want = {12'(h), 12'(v), a2, (h == 0) && (v < 600), (h == 0) && (v == 0),
                    a, ~hr, ~vr, (a ? 8'(hq) : 8'd0)};
            got  = {if0.x, if0.y, if0.req_active, if0.line_start, if0.frame_start,
                    if0.de, if0.hsync, if0.vsync, if0.blue, if0.green, if0.red};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL default_slot m=%0d got=%h exp=%h", m, got, want);
            end
            if (m >= 4) begin
                if (!if0.hsync) hs_low++;
                if (if0.de) de_hi++;
            end
        end
        if0.pix_en = 1'b0;
        checks++;
        if (hs_low !== 360) begin
            failures++;
            $display("FAIL default_hsync_width got=%0d exp=360", hs_low);
        end
        checks++;
        if (de_hi !== 3072) begin
            failures++;
            $display("FAIL default_de_count got=%0d exp=3072", de_hi);
        end
    endtask

    task automatic test_mode_640();
        int h, v, hq, vq, hs_hi, req_rise, de_rise;
        bit a, hr, vr, a2, hr2, vr2;
        logic [37:0] got, want;
        hs_hi = 0; req_rise = -1; de_rise = -1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int m = 1; m <= 802; m++) begin
            slot_model(640, 16, 96, 48, 480, 10, 2, 33, m - 2, hq, vq, a, hr, vr);
            if1.rgb_in = 8'(hq);
            if1.pix_en = 1'b1;
            @(posedge clk);
            #1;
            slot_model(640, 16, 96, 48, 480, 10, 2, 33, m, h, v, a2, hr2, vr2);
            want = {12'(h), 12'(v), a2, (h == 0) && (v < 480), (h == 0) && (v == 0),
                    a, hr, vr, (a ? 8'(hq) : 8'd0)};
            got  = {if1.x, if1.y, if1.req_active, if1.line_start, if1.frame_start,
                    if1.de, if1.hsync, if1.vsync, if1.blue, if1.green, if1.red};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL mode640_slot m=%0d got=%h exp=%h", m, got, want);
            end
            if (m >= 2 && m <= 801 && if1.hsync) hs_hi++;
            if (if1.req_active && req_rise < 0) req_rise = m;
            if (if1.de && de_rise < 0) de_rise = m;
        end
        if1.pix_en = 1'b0;
        checks++;
        if (hs_hi !== 96) begin
            failures++;
            $display("FAIL mode640_hsync_width got=%0d exp=96", hs_hi);
        end
        checks++;
        if (de_rise - req_rise !== 2) begin
            failures++;
            $display("FAIL pipe1_latency got=%0d exp=2", de_rise - req_rise);
        end
    endtask

    // mode 0: pix_en always 1, 1: alternating, 2: random
    task automatic test_pix_en_patterns(input int mode);
        int n, h, v, hq, vq, hs_low, vs_low, de_hi, req_rise, de_rise;
        bit a, hr, vr, a2, hr2, vr2, en;
        logic [37:0] got, want;
        n = 0; hs_low = 0; vs_low = 0; de_hi = 0; req_rise = -1; de_rise = -1;
        rst = 1'b1;
        if2.pix_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4000 && n < 320; c++) begin
            case (mode)
                0:       en = 1'b1;
                1:       en = (c % 2 == 0);
                default: en = 1'($urandom_range(0, 1));
            endcase
            slot_model(8, 0, 3, 2, 4, 2, 2, 0, n - 4, hq, vq, a, hr, vr);
            if2.rgb_in = tiny_pat(hq, vq);
            if2.pix_en = en;
            @(posedge clk);
            #1;
            if (en) n++;
            slot_model(8, 0, 3, 2, 4, 2, 2, 0, n, h, v, a2, hr2, vr2);
            slot_model(8, 0, 3, 2, 4, 2, 2, 0, n - 5, hq, vq, a, hr, vr);
            want = {12'(h), 12'(v), a2, (h == 0) && (v < 4), (h == 0) && (v == 0),
                    a, ~hr, ~vr, (a ? tiny_pat(hq, vq) : 8'd0)};
            got  = {if2.x, if2.y, if2.req_active, if2.line_start, if2.frame_start,
                    if2.de, if2.hsync, if2.vsync, if2.blue, if2.green, if2.red};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL tiny_slot mode=%0d c=%0d n=%0d got=%h exp=%h", mode, c, n, got, want);
            end
            if (en) begin
                if (if2.req_active && req_rise < 0) req_rise = n;
                if (if2.de && de_rise < 0) de_rise = n;
                if (n >= 6 && n <= 109) begin
                    if (!if2.hsync) hs_low++;
                    if (!if2.vsync) vs_low++;
                    if (if2.de) de_hi++;
                end
            end
        end
        if2.pix_en = 1'b0;
        checks++;
        if (n < 320) begin
            failures++;
            $display("FAIL tiny_budget mode=%0d got=%0d edges exp=320", mode, n);
        end
        checks++;
        if (hs_low !== 24) begin
            failures++;
            $display("FAIL tiny_hsync_frame mode=%0d got=%0d exp=24", mode, hs_low);
        end
        checks++;
        if (vs_low !== 26) begin
            failures++;
            $display("FAIL tiny_vsync_frame mode=%0d got=%0d exp=26", mode, vs_low);
        end
        checks++;
        if (de_hi !== 32) begin
            failures++;
            $display("FAIL tiny_de_frame mode=%0d got=%0d exp=32", mode, de_hi);
        end
        checks++;
        if (de_rise - req_rise !== 5) begin
            failures++;
            $display("FAIL pipe4_latency mode=%0d got=%0d exp=5", mode, de_rise - req_rise);
        end
    endtask

    task automatic test_reset_mid_frame();
        int h, v, hq, vq;
        bit a, hr, vr, a2, hr2, vr2;
        logic [37:0] got, want;
        rst = 1'b1;
        if2.pix_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if2.rgb_in = 8'hFF;
        if2.pix_en = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        checks++;
        if ({if2.x, if2.y, if2.de} !== {12'd5, 12'd2, 1'b1}) begin
            failures++;
            $display("FAIL mid_position got x=%0d y=%0d de=%b exp x=5 y=2 de=1", if2.x, if2.y, if2.de);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        got = {if2.x, if2.y, if2.req_active, if2.line_start, if2.frame_start,
               if2.de, if2.hsync, if2.vsync, if2.blue, if2.green, if2.red};
        checks++;
        if (got !== {12'd12, 12'd7, 4'b0000, 2'b11, 8'd0}) begin
            failures++;
            $display("FAIL mid_reset_state got=%h exp=%h", got, {12'd12, 12'd7, 4'b0000, 2'b11, 8'd0});
        end
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            slot_model(8, 0, 3, 2, 4, 2, 2, 0, n - 5, hq, vq, a, hr, vr);
            if2.rgb_in = tiny_pat(hq, vq);
            @(posedge clk);
            #1;
            slot_model(8, 0, 3, 2, 4, 2, 2, 0, n, h, v, a2, hr2, vr2);
            want = {12'(h), 12'(v), a2, (h == 0) && (v < 4), (h == 0) && (v == 0),
                    a, ~hr, ~vr, (a ? tiny_pat(hq, vq) : 8'd0)};
            got  = {if2.x, if2.y, if2.req_active, if2.line_start, if2.frame_start,
                    if2.de, if2.hsync, if2.vsync, if2.blue, if2.green, if2.red};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL mid_restart n=%0d got=%h exp=%h", n, got, want);
            end
        end
        if2.pix_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_default_lines();
        test_mode_640();
        test_pix_en_patterns(0);
        test_pix_en_patterns(1);
        test_pix_en_patterns(2);
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with pixel-clock enable, programmable sync polarity and a configurable pixel-data pipeline delay.
- Produces pixel coordinates and line/frame strobes for an upstream pattern or framebuffer source.
- Accepts that source's RGB a fixed number of pixels later and drives the masked RGB, hsync and vsync to the DAC pins, all mutually aligned.
- Sits between image-generation logic and the board VGA connector; replaces the fixed-mode 1024x600 generator.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FRONT, 80, horizontal front porch (pixels)
- H_SYNC, 120, hsync pulse width (pixels)
- H_BACK, 122, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FRONT, 34, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BACK, 26, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- PIPE, 2, pixel-data latency of the upstream source in pixel slots, legal range 1..4
- R_W / G_W / B_W, 3 / 3 / 2, colour channel widths
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel-slot enable; all counters and pipeline stages advance only on clk edges with pix_en=1
- x  out  12  column of the pixel being requested (0..H_ACTIVE-1 when req_active)
- y  out  12  row of the pixel being requested
- req_active  out  1  current (x,y) lies inside the visible area
- line_start  out  1  one-slot strobe, high when x=0 and the line is visible
- frame_start  out  1  one-slot strobe, high when x=0 and y=0
- rgb_in  in  R_W+G_W+B_W  source pixel {B,G,R} for the request issued PIPE slots earlier
- red / green / blue  out  R_W / G_W / B_W  registered colour to the DAC, zero outside the visible area
- hsync, vsync  out  1  registered sync outputs
- de  out  1  registered data-enable, aligned with red/green/blue

## Operation
- Derived constants: H_TOTAL = sum of the horizontal parameters (1346 default); V_TOTAL = sum of the vertical parameters (666 default).
- Horizontal counter h and vertical counter v advance on pix_en.
  - h wraps H_TOTAL-1 -> 0.
  - v increments when h wraps, and itself wraps V_TOTAL-1 -> 0.
- Region order within a line: active [0, H_ACTIVE), front porch, sync, back porch. Lines follow the same order within a frame.
- Sync regions:
  - hsync region is h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vsync region is v in the analogous vertical window, spanning whole lines.
- x = h and y = v, exposed directly from the counter registers. They are meaningful as coordinates only when req_active=1.
- Delay line: {req_active, hsync-region, vsync-region} enter a PIPE-stage shift register that advances on pix_en.
- Output stage: the final stage drives de and the sync outputs. Each sync output equals the polarity parameter inside its region and the inverse outside.
- RGB output: on each pix_en edge, red/green/blue capture rgb_in when the final-stage active bit is 1, else 0.
- Strobes line_start and frame_start are combinational from h and v. They are only meaningful on cycles with pix_en=1.

## Timing
- Reset:
  - h = H_TOTAL-1, v = V_TOTAL-1.
  - Delay line cleared to inactive.
  - Outputs: de=0; red/green/blue=0; hsync=~HSYNC_POL; vsync=~VSYNC_POL; req_active=0; line_start=0; frame_start=0; x=H_TOTAL-1; y=V_TOTAL-1.
- Frame start after reset: the first pix_en after reset moves to (0,0), and frame_start and line_start then read 1.
- Latency: a request at slot k reaches de/hsync/vsync/RGB after exactly PIPE+1 pix_en edges. rgb_in is sampled on edge k+PIPE+1.
- pix_en=0: every register holds its value, including outputs and strobes. There are no skipped or duplicated pixels.
- Reset mid-frame: the next cycle equals the reset state regardless of pix_en, and in-flight pipeline pixels are discarded.
- Sync regions are non-empty by construction. Zero-length front or back porches are legal and must still give correct region boundaries.

## Structure
- Shared package vga_pkg holds:
  - the mode-timing record typedef (active/front/sync/back per axis);
  - named default constants for 1024x600@50 MHz and 640x480@25 MHz;
  - a function returning the total from a timing record.
- One sub-module, vga_axis_counter, is instantiated twice (horizontal, vertical). It provides:
  - a wrap counter with enable;
  - active/sync region flags;
  - a wrap output that chains the horizontal counter into the vertical enable.

## Test plan
- Reset, then pix_en=1 constantly, defaults -> frame_start on the first slot after reset; hsync low for exactly 120 slots every 1346; vsync low for exactly 6×1346 slots every 666×1346.
- rgb_in = {x[7:0]} with PIPE=2 and a 2-slot model source -> the DAC pixel at output-active slot n equals n[7:0]; de high for exactly 1024 slots per visible line; RGB 0 in every blanking slot.
- pix_en toggled 1/0 (and separately a random pattern) -> output sequence identical to the pix_en=1 run after removing held cycles.
- HSYNC_POL=1, VSYNC_POL=1, 640x480 mode -> sync pulses high, 96 and 2 units wide, H_TOTAL=800, V_TOTAL=525.
- rst asserted at h=500, v=300 -> the next cycle shows reset values; the first visible pixel after release is (0,0) with frame_start.
- PIPE=1 and PIPE=4 -> de rises exactly PIPE+1 pix_en edges after req_active rises.
